// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the unified memory data port among NUM_REQ LSUs.
// Granted IDs queue in an in-order FIFO so each memory response returns to its issuer.
module dmem_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 2,
    // Widths mirror pkg_opengpu ADDR_WIDTH / DATA_WIDTH.
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wdata,
    input  logic [NUM_REQ*4-1:0]                 req_be,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_rdata,
    output logic                                 dmem_req,
    output logic                                 dmem_we,
    output logic [ADDR_WIDTH-1:0]                dmem_addr,
    output logic [DATA_WIDTH-1:0]                dmem_wdata,
    output logic [3:0]                           dmem_be,
    input  logic [DATA_WIDTH-1:0]                dmem_rdata,
    input  logic                                 dmem_valid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 err_unexpected_rsp
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  head_id;
    logic             found;
    logic             pop;
    logic             push;
    logic             can_issue;
    logic [ID_W-1:0]  id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             err;

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] cand;
        idx    = 0;
        cand   = '0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign head_id = id_fifo[rd_ptr];

    always_comb begin
        pop       = rst_n && dmem_valid && (count != '0);
        can_issue = (count < CNT_MAX) || pop;
        push      = rst_n && can_issue && found;

        req_ready  = '0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_be    = '0;
        if (push) begin
            req_ready[winner] = 1'b1;
            dmem_req          = 1'b1;
            dmem_we           = req_we[winner];
            dmem_addr         = req_addr[32'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            dmem_wdata        = req_wdata[32'(winner)*DATA_WIDTH +: DATA_WIDTH];
            dmem_be           = req_be[32'(winner)*4 +: 4];
        end

        rsp_valid = '0;
        rsp_rdata = '0;
        if (pop) begin
            rsp_valid[head_id] = 1'b1;
            rsp_rdata          = dmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                id_fifo[i] <= '0;
            end
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= winner;
                wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                rr_ptr          <= (winner == ID_LAST) ? '0 : winner + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A response with nothing outstanding can never be routed; latch it.
            if (dmem_valid && (count == '0)) begin
                err <= 1'b1;
            end
        end
    end

    assign outstanding        = count;
    assign err_unexpected_rsp = err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at default depth with a storing
// memory model, one at depth 1 with a holdable response path for back-pressure.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;

    logic [3:0]   req_valid, req_ready, req_we, rsp_valid;
    logic [127:0] req_addr, req_wdata;
    logic [15:0]  req_be;
    logic [31:0]  rsp_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic         dmem_req, dmem_we, dmem_valid;
    logic [3:0]   dmem_be;
    logic [1:0]   outstanding;
    logic         err_unexpected_rsp;

    logic [3:0]   bp_req_valid, bp_req_ready, bp_req_we, bp_rsp_valid;
    logic [127:0] bp_req_addr, bp_req_wdata;
    logic [15:0]  bp_req_be;
    logic [31:0]  bp_rsp_rdata, bp_dmem_addr, bp_dmem_wdata, bp_dmem_rdata;
    logic         bp_dmem_req, bp_dmem_we, bp_dmem_valid;
    logic [3:0]   bp_dmem_be;
    logic [0:0]   bp_outstanding;
    logic         bp_err;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
        .outstanding(outstanding), .err_unexpected_rsp(err_unexpected_rsp)
    );

    dmem_arbiter #(.MAX_OUTSTANDING(1)) u_dut_bp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(bp_req_valid), .req_ready(bp_req_ready), .req_we(bp_req_we),
        .req_addr(bp_req_addr), .req_wdata(bp_req_wdata), .req_be(bp_req_be),
        .rsp_valid(bp_rsp_valid), .rsp_rdata(bp_rsp_rdata),
        .dmem_req(bp_dmem_req), .dmem_we(bp_dmem_we), .dmem_addr(bp_dmem_addr),
        .dmem_wdata(bp_dmem_wdata), .dmem_be(bp_dmem_be),
        .dmem_rdata(bp_dmem_rdata), .dmem_valid(bp_dmem_valid),
        .outstanding(bp_outstanding), .err_unexpected_rsp(bp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model, latency 1, word-indexed by addr[9:2]; 0x100 preloaded.
    logic [31:0] mem [0:255];
    logic        m_valid;
    logic [31:0] m_rdata;
    logic        inj;

    assign dmem_valid = m_valid | inj;
    assign dmem_rdata = m_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_rdata <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[64] <= 32'hDEAD_BEEF;
        end else begin
            m_valid <= dmem_req;
            if (dmem_req) begin
                if (dmem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (dmem_be[b]) mem[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
                    m_rdata <= '0;
                end else begin
                    m_rdata <= mem[dmem_addr[9:2]];
                end
            end
        end
    end

    // Second model: one pending response, withheld while bp_hold is set.
    logic        bp_pend, bp_hold;
    logic [31:0] bp_pend_data;

    assign bp_dmem_valid = bp_pend & ~bp_hold;
    assign bp_dmem_rdata = bp_pend_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_pend      <= 1'b0;
            bp_pend_data <= '0;
        end else begin
            if (bp_dmem_valid) bp_pend <= 1'b0;
            if (bp_dmem_req) begin
                bp_pend      <= 1'b1;
                bp_pend_data <= bp_dmem_addr ^ 32'hA5A5_0000;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        req_we[i]             = we;
        req_addr[32*i +: 32]  = addr;
        req_wdata[32*i +: 32] = wdata;
        req_be[4*i +: 4]      = be;
    endtask

    task automatic bp_set_req(input int i, input logic [31:0] addr);
        bp_req_we[i]             = 1'b0;
        bp_req_addr[32*i +: 32]  = addr;
        bp_req_wdata[32*i +: 32] = '0;
        bp_req_be[4*i +: 4]      = 4'hF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_oh;
        rst_n = 1'b0;
        inj = 1'b0;
        bp_hold = 1'b0;
        req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        bp_req_valid = '0; bp_req_we = '0; bp_req_addr = '0; bp_req_wdata = '0; bp_req_be = '0;
        req_valid = 4'b1111;

        // Reset: everything quiet even with requests pending.
        @(negedge clk);
        check_eq("rst_ready", req_ready, 4'b0000);
        check_eq("rst_dmem_req", dmem_req, 1'b0);
        check_eq("rst_outstanding", outstanding, 2'd0);
        check_eq("rst_err", err_unexpected_rsp, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 4'b0000);
        rst_n = 1'b1;
        req_valid = '0;
        next_cycle();

        // Single read by requester 2.
        set_req(2, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        req_valid = 4'b0100;
        @(negedge clk);
        check_eq("rd_ready", req_ready, 4'b0100);
        check_eq("rd_dmem_req", dmem_req, 1'b1);
        check_eq("rd_dmem_addr", dmem_addr, 32'h0000_0100);
        check_eq("rd_dmem_we", dmem_we, 1'b0);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check_eq("rd_rsp_valid", rsp_valid, 4'b0100);
        check_eq("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check_eq("rd_outstanding_t1", outstanding, 2'd1);
        next_cycle();
        @(negedge clk);
        check_eq("rd_outstanding_t2", outstanding, 2'd0);
        check_eq("rd_rsp_idle", rsp_valid, 4'b0000);

        // Round-robin from reset: all four held valid for eight cycles.
        next_cycle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_oh = 4'b0001 << (k % 4);
            check_eq($sformatf("rr_grant_%0d", k), req_ready, exp_oh);
            if (k > 0) begin
                exp_oh = 4'b0001 << ((k - 1) % 4);
                check_eq($sformatf("rr_rsp_%0d", k), rsp_valid, exp_oh);
            end
            next_cycle();
        end
        req_valid = '0;
        @(negedge clk);
        check_eq("rr_rsp_last", rsp_valid, 4'b1000);
        check_eq("rr_rdata_last", rsp_rdata, 32'hDEAD_BEEF);
        next_cycle();

        // Requester 1 writes bytes 0..1, requester 3 reads back.
        set_req(1, 1'b1, 32'h0000_0200, 32'h1122_3344, 4'b0011);
        req_valid = 4'b0010;
        @(negedge clk);
        check_eq("wr_ready", req_ready, 4'b0010);
        check_eq("wr_dmem_we", dmem_we, 1'b1);
        check_eq("wr_dmem_addr", dmem_addr, 32'h0000_0200);
        check_eq("wr_dmem_wdata", dmem_wdata, 32'h1122_3344);
        check_eq("wr_dmem_be", dmem_be, 4'b0011);
        next_cycle();
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(3, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        req_valid = 4'b1000;
        @(negedge clk);
        check_eq("wr_ack", rsp_valid, 4'b0010);
        check_eq("rb_ready", req_ready, 4'b1000);
        check_eq("rb_dmem_we", dmem_we, 1'b0);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check_eq("rb_rsp_valid", rsp_valid, 4'b1000);
        check_eq("rb_rsp_rdata", rsp_rdata, 32'h0000_3344);

        // Response with nothing outstanding.
        next_cycle();
        inj = 1'b1;
        @(negedge clk);
        check_eq("unexp_rsp_valid", rsp_valid, 4'b0000);
        check_eq("unexp_err_same_cycle", err_unexpected_rsp, 1'b0);
        next_cycle();
        inj = 1'b0;
        @(negedge clk);
        check_eq("unexp_err_set", err_unexpected_rsp, 1'b1);
        next_cycle();
        @(negedge clk);
        check_eq("unexp_err_sticky", err_unexpected_rsp, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("unexp_err_cleared", err_unexpected_rsp, 1'b0);
        rst_n = 1'b1;
        next_cycle();

        // Reset mid-stream with one outstanding and rr_ptr = 2.
        set_req(1, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        req_valid = 4'b0010;
        @(negedge clk);
        check_eq("ms_grant1", req_ready, 4'b0010);
        next_cycle();
        set_req(2, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        set_req(3, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        req_valid = 4'b1110;
        @(negedge clk);
        check_eq("ms_outstanding", outstanding, 2'd1);
        check_eq("ms_rsp_valid", rsp_valid, 4'b0010);
        check_eq("ms_grant_ptr2", req_ready, 4'b0100);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("ms_rst_ready", req_ready, 4'b0000);
        check_eq("ms_rst_dmem_req", dmem_req, 1'b0);
        check_eq("ms_rst_rsp_valid", rsp_valid, 4'b0000);
        check_eq("ms_rst_rdata", rsp_rdata, 32'h0);
        check_eq("ms_rst_outstanding", outstanding, 2'd0);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("ms_post_grant", req_ready, 4'b0010);
        check_eq("ms_post_dmem_req", dmem_req, 1'b1);
        next_cycle();
        req_valid = '0;
        next_cycle();
        next_cycle();

        // Back-pressure on the depth-1 instance.
        bp_hold = 1'b1;
        bp_set_req(0, 32'h0000_0010);
        bp_set_req(1, 32'h0000_0020);
        bp_req_valid = 4'b0011;
        @(negedge clk);
        check_eq("bp_first_grant", bp_req_ready, 4'b0001);
        check_eq("bp_first_dmem_req", bp_dmem_req, 1'b1);
        next_cycle();
        bp_req_valid = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq($sformatf("bp_full_outstanding_%0d", k), bp_outstanding, 1'b1);
            check_eq($sformatf("bp_full_ready_%0d", k), bp_req_ready, 4'b0000);
            check_eq($sformatf("bp_full_dmem_req_%0d", k), bp_dmem_req, 1'b0);
            check_eq($sformatf("bp_full_rsp_%0d", k), bp_rsp_valid, 4'b0000);
            next_cycle();
        end
        bp_hold = 1'b0;
        @(negedge clk);
        check_eq("bp_release_rsp", bp_rsp_valid, 4'b0001);
        check_eq("bp_release_rdata", bp_rsp_rdata, 32'hA5A5_0010);
        check_eq("bp_release_grant", bp_req_ready, 4'b0010);
        check_eq("bp_release_outstanding", bp_outstanding, 1'b1);
        next_cycle();
        bp_req_valid = '0;
        @(negedge clk);
        check_eq("bp_second_rsp", bp_rsp_valid, 4'b0010);
        check_eq("bp_second_rdata", bp_rsp_rdata, 32'hA5A5_0020);
        next_cycle();
        @(negedge clk);
        check_eq("bp_drained", bp_outstanding, 1'b0);
        check_eq("bp_err", bp_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
